// File: rtl/pc_ctrl.sv
// Program-counter and fetch-redirect controller for the five-stage pipeline front end.
// Optional misaligned-target trapping is enabled by defining the PC_TRAP_EN macro.
module pc_ctrl #(
    parameter logic [19:0] RESET_PC = 20'h00000,
    parameter logic [19:0] TRAP_VEC = 20'h00100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] IF_PC,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [19:0] br_target,
    input  logic        imem_ready,
    output logic        PCWrite,
    output logic [19:0] nextPC,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        imem_req
`ifdef PC_TRAP_EN
    ,
    output logic        trap,
    output logic [19:0] epc
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [19:0] pend_pc;
    logic [19:0] pend_pc_nx;
    logic [19:0] pc_plus4;
    logic [19:0] redirect_pc;

    assign pc_plus4 = IF_PC + 20'd4;

`ifdef PC_TRAP_EN
    logic misaligned;

    // A target that is not word aligned is diverted to the trap vector.
    assign misaligned  = |br_target[1:0];
    assign redirect_pc = misaligned ? TRAP_VEC : {br_target[19:2], 2'b00};
    assign trap        = !reset && (state == RUN) && br_taken && misaligned;
`else
    logic unused_br_low;

    assign unused_br_low = ^br_target[1:0];
    assign redirect_pc   = {br_target[19:2], 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BOOT;
            pend_pc <= 20'h00000;
`ifdef PC_TRAP_EN
            epc     <= 20'h00000;
`endif
        end else begin
            state   <= state_nx;
            pend_pc <= pend_pc_nx;
`ifdef PC_TRAP_EN
            if (trap) begin
                epc <= br_target;
            end
`endif
        end
    end

    // Reset forces the BOOT outputs even before the state register has been cleared.
    always_comb begin
        state_nx    = state;
        pend_pc_nx  = pend_pc;
        PCWrite     = 1'b0;
        nextPC      = IF_PC;
        IF_ID_write = 1'b0;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        imem_req    = 1'b0;
        if (reset) begin
            PCWrite     = 1'b1;
            nextPC      = RESET_PC;
            IF_ID_flush = 1'b1;
            state_nx    = BOOT;
        end else begin
            case (state)
                BOOT: begin
                    PCWrite     = 1'b1;
                    nextPC      = RESET_PC;
                    IF_ID_flush = 1'b1;
                    state_nx    = RUN;
                end
                RUN: begin
                    imem_req = 1'b1;
                    if (br_taken) begin
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                        if (imem_ready) begin
                            PCWrite  = 1'b1;
                            nextPC   = redirect_pc;
                            state_nx = FLUSH;
                        end else begin
                            pend_pc_nx = redirect_pc;
                            state_nx   = PEND;
                        end
                    end else if (stall) begin
                        ID_EX_flush = 1'b1;
                    end else if (imem_ready) begin
                        PCWrite     = 1'b1;
                        nextPC      = pc_plus4;
                        IF_ID_write = 1'b1;
                    end
                end
                // The redirect is already captured, so later branches and stalls are ignored.
                PEND: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        PCWrite     = 1'b1;
                        nextPC      = pend_pc;
                        IF_ID_flush = 1'b1;
                        state_nx    = FLUSH;
                    end
                end
                FLUSH: begin
                    imem_req    = 1'b1;
                    IF_ID_flush = 1'b1;
                    if (imem_ready) begin
                        PCWrite  = 1'b1;
                        nextPC   = pc_plus4;
                        state_nx = RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the fetch controller.
module tb_pc_ctrl;

    localparam logic [19:0] RESET_PC = 20'h00000;
    localparam logic [19:0] TRAP_VEC = 20'h00100;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] IF_PC;
    logic        stall;
    logic        br_taken;
    logic [19:0] br_target;
    logic        imem_ready;
    logic        PCWrite;
    logic [19:0] nextPC;
    logic        IF_ID_write;
    logic        IF_ID_flush;
    logic        ID_EX_flush;
    logic        imem_req;
`ifdef PC_TRAP_EN
    logic        trap;
    logic [19:0] epc;
`endif

    pc_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk(clk),
        .reset(reset),
        .IF_PC(IF_PC),
        .stall(stall),
        .br_taken(br_taken),
        .br_target(br_target),
        .imem_ready(imem_ready),
        .PCWrite(PCWrite),
        .nextPC(nextPC),
        .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush),
        .imem_req(imem_req)
`ifdef PC_TRAP_EN
        ,
        .trap(trap),
        .epc(epc)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    bit check_en = 1'b0;

    // Model: the PC register the bench owns, plus what the controller still owes.
    logic [19:0] pc = 20'h00000;
    bit          m_boot = 1'b0, m_pend = 1'b0, m_flush = 1'b0;
    logic [19:0] m_pend_addr = 20'h0, m_epc = 20'h0;
    bit          nx_boot, nx_pend, nx_flush;
    logic [19:0] nx_pend_addr, nx_epc;
    bit          exp_pcw, exp_ifw, exp_iff, exp_idf, exp_req, exp_trap;
    logic [19:0] exp_npc;

    assign IF_PC = pc;

    task automatic checkOutput(input string name, input logic [19:0] actual, input logic [19:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [19:0] plus4(input logic [19:0] a);
        return 20'((int'(a) + 4) % (1 << 20));
    endfunction

    task automatic evalModel();
        logic [19:0] tgt;
        exp_pcw = 0; exp_npc = 20'h0; exp_ifw = 0; exp_iff = 0; exp_idf = 0; exp_req = 0; exp_trap = 0;
        nx_boot = m_boot; nx_pend = m_pend; nx_pend_addr = m_pend_addr; nx_flush = m_flush; nx_epc = m_epc;
        tgt = 20'((int'(br_target) / 4) * 4);
`ifdef PC_TRAP_EN
        if (int'(br_target) % 4 != 0) tgt = TRAP_VEC;
`endif
        if (reset || m_boot) begin
            exp_pcw = 1; exp_npc = RESET_PC; exp_iff = 1;
            nx_boot = reset; nx_pend = 0; nx_flush = 0;
            if (reset) begin nx_pend_addr = 20'h0; nx_epc = 20'h0; end
        end else if (m_pend) begin
            exp_req = 1;
            if (imem_ready) begin
                exp_pcw = 1; exp_npc = m_pend_addr; exp_iff = 1; nx_pend = 0; nx_flush = 1;
            end
        end else if (m_flush) begin
            exp_req = 1; exp_iff = 1;
            if (imem_ready) begin exp_pcw = 1; exp_npc = plus4(pc); nx_flush = 0; end
        end else begin
            exp_req = 1;
            if (br_taken) begin
                exp_iff = 1; exp_idf = 1;
`ifdef PC_TRAP_EN
                if (int'(br_target) % 4 != 0) begin exp_trap = 1; nx_epc = br_target; end
`endif
                if (imem_ready) begin exp_pcw = 1; exp_npc = tgt; nx_flush = 1; end
                else begin nx_pend = 1; nx_pend_addr = tgt; end
            end else if (stall) begin
                exp_idf = 1;
            end else if (imem_ready) begin
                exp_pcw = 1; exp_npc = plus4(pc); exp_ifw = 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit st, input bit br, input logic [19:0] tgt,
                                 input bit rdy, input bit use_pc, input logic [19:0] pcv);
        @(posedge clk);
        m_boot = nx_boot; m_pend = nx_pend; m_pend_addr = nx_pend_addr; m_flush = nx_flush; m_epc = nx_epc;
        if (exp_pcw) pc = exp_npc;
        #1;
        reset = r; stall = st; br_taken = br; br_target = tgt; imem_ready = rdy;
        if (use_pc) pc = pcv;
        evalModel();
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("PCWrite", {19'h0, PCWrite}, {19'h0, exp_pcw});
            checkOutput("IF_ID_write", {19'h0, IF_ID_write}, {19'h0, exp_ifw});
            checkOutput("IF_ID_flush", {19'h0, IF_ID_flush}, {19'h0, exp_iff});
            checkOutput("ID_EX_flush", {19'h0, ID_EX_flush}, {19'h0, exp_idf});
            checkOutput("imem_req", {19'h0, imem_req}, {19'h0, exp_req});
            if (exp_pcw) checkOutput("nextPC", nextPC, exp_npc);
`ifdef PC_TRAP_EN
            checkOutput("trap", {19'h0, trap}, {19'h0, exp_trap});
            checkOutput("epc", epc, m_epc);
`endif
        end
    end

    initial begin
        reset = 1; stall = 0; br_taken = 0; br_target = 20'h0; imem_ready = 1;
        evalModel();
        check_en = 1'b1;

        repeat (2) begin
            applyStimulus(1, 0, 0, 20'h0, 1, 0, 20'h0); #2;
            checkOutput("lit_reset_pcwrite", {19'h0, PCWrite}, 20'h1);
            checkOutput("lit_reset_nextpc", nextPC, 20'h00000);
            checkOutput("lit_reset_req", {19'h0, imem_req}, 20'h0);
        end
        applyStimulus(0, 0, 0, 20'h0, 1, 0, 20'h0); #2;
        checkOutput("lit_boot_nextpc", nextPC, 20'h00000);
        checkOutput("lit_boot_flush", {19'h0, IF_ID_flush}, 20'h1);
        applyStimulus(0, 0, 0, 20'h0, 1, 0, 20'h0); #2;
        checkOutput("lit_seq_4", nextPC, 20'h00004);
        applyStimulus(0, 0, 0, 20'h0, 1, 0, 20'h0); #2;
        checkOutput("lit_seq_8", nextPC, 20'h00008);
        applyStimulus(0, 0, 0, 20'h0, 1, 0, 20'h0); #2;
        checkOutput("lit_seq_12", nextPC, 20'h0000C);

        applyStimulus(0, 1, 0, 20'h0, 1, 1, 20'h00010);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) applyStimulus(0, 1, 0, 20'h0, 1, 0, 20'h0);
            #2;
            checkOutput("lit_stall_pcwrite", {19'h0, PCWrite}, 20'h0);
            checkOutput("lit_stall_ifwrite", {19'h0, IF_ID_write}, 20'h0);
            checkOutput("lit_stall_idflush", {19'h0, ID_EX_flush}, 20'h1);
        end
        applyStimulus(0, 0, 0, 20'h0, 1, 0, 20'h0); #2;
        checkOutput("lit_stall_resume", nextPC, 20'h00014);

        applyStimulus(0, 0, 1, 20'h00200, 1, 0, 20'h0); #2;
        checkOutput("lit_br_pcwrite", {19'h0, PCWrite}, 20'h1);
        checkOutput("lit_br_nextpc", nextPC, 20'h00200);
        checkOutput("lit_br_flushes", {18'h0, IF_ID_flush, ID_EX_flush}, 20'h3);
        applyStimulus(0, 0, 0, 20'h0, 0, 0, 20'h0); #2;
        checkOutput("lit_flush_state", {19'h0, IF_ID_flush}, 20'h1);
        applyStimulus(0, 0, 0, 20'h0, 1, 0, 20'h0); #2;
        checkOutput("lit_flush_exit", nextPC, 20'h00204);

        applyStimulus(0, 0, 1, 20'h00300, 0, 0, 20'h0); #2;
        checkOutput("lit_pend_enter", {19'h0, PCWrite}, 20'h0);
        repeat (2) begin
            applyStimulus(0, 0, 0, 20'h0, 0, 0, 20'h0); #2;
            checkOutput("lit_pend_hold", {19'h0, PCWrite}, 20'h0);
        end
        applyStimulus(0, 1, 1, 20'h00500, 1, 0, 20'h0); #2;
        checkOutput("lit_pend_release", nextPC, 20'h00300);
        checkOutput("lit_pend_pcwrite", {19'h0, PCWrite}, 20'h1);
        applyStimulus(0, 0, 0, 20'h0, 1, 0, 20'h0);

        applyStimulus(0, 0, 0, 20'h0, 1, 1, 20'hFFFFC); #2;
        checkOutput("lit_wrap", nextPC, 20'h00000);

        applyStimulus(0, 0, 1, 20'h00202, 1, 0, 20'h0); #2;
`ifdef PC_TRAP_EN
        checkOutput("lit_trap_nextpc", nextPC, 20'h00100);
        checkOutput("lit_trap_pulse", {19'h0, trap}, 20'h1);
        applyStimulus(0, 0, 0, 20'h0, 1, 0, 20'h0); #2;
        checkOutput("lit_trap_epc", epc, 20'h00202);
        checkOutput("lit_trap_once", {19'h0, trap}, 20'h0);
`else
        checkOutput("lit_align_nextpc", nextPC, 20'h00200);
        applyStimulus(0, 0, 0, 20'h0, 1, 0, 20'h0);
`endif

        applyStimulus(0, 0, 1, 20'h00400, 0, 0, 20'h0);
        applyStimulus(1, 0, 0, 20'h0, 1, 0, 20'h0); #2;
        checkOutput("lit_midpend_reset", nextPC, 20'h00000);
        applyStimulus(0, 0, 0, 20'h0, 1, 0, 20'h0); #2;
        checkOutput("lit_midpend_boot", nextPC, 20'h00000);
        applyStimulus(0, 0, 0, 20'h0, 1, 0, 20'h0); #2;
        checkOutput("lit_midpend_run", nextPC, 20'h00004);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 5) == 0, 20'($urandom), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 19) == 0, 20'($urandom) & 20'hFFFFC);
        end

        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
